// File: rtl/iadc_pkg.sv
// Shared definitions for the incremental-ADC decimation chain.
// Holds the conversion FSM state type, default sizing constants and the
// accumulator width helpers (also used by the downstream decimator).
package iadc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_MOD = 2'd1,
    ST_INTEGRATE = 2'd2,
    ST_DUMP      = 2'd3
  } iadc_state_e;

  // Default sizing: 512 samples per conversion, 12-bit code
  localparam int IADC_OSR   = 512;
  localparam int IADC_SHIFT = 5;
  localparam int IADC_OUT_W = 12;

  // Sample counter width: counts 0..OSR-1
  function automatic int cnt_w(input int osr);
    return $clog2(osr);
  endfunction

  // First integrator holds up to OSR (all-ones input)
  function automatic int acc1_w(input int osr);
    return $clog2(osr) + 1;
  endfunction

  // Second integrator holds up to 1+2+..+OSR = OSR*(OSR+1)/2
  function automatic int acc2_w(input int osr);
    return $clog2(osr * (osr + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/iadc_sinc2_filter_if.sv
// Bundle between the modulator/sampler side and the sinc2 filter.
// Ports: en, bit_in (toward filter); mod_rst, busy, valid, data_out (from filter).
// No backpressure: valid is a one-cycle strobe, data_out is held until the next one.
interface iadc_sinc2_filter_if
  import iadc_pkg::*;
#(
  parameter int OUT_W = IADC_OUT_W
) ();

  logic             en;        // level enable, conversions repeat while high
  logic             bit_in;    // modulator output bit
  logic             mod_rst;   // active-high reset to the analog modulator
  logic             busy;      // conversion in progress
  logic             valid;     // one-cycle strobe when data_out updates
  logic [OUT_W-1:0] data_out;  // latest conversion result

  // Driver side (modulator/control)
  modport master (
    output en,
    output bit_in,
    input  mod_rst,
    input  busy,
    input  valid,
    input  data_out
  );

  // Filter side
  modport slave (
    input  en,
    input  bit_in,
    output mod_rst,
    output busy,
    output valid,
    output data_out
  );

endinterface

// File: rtl/iadc_sinc2_integrator.sv
// Cascaded two-stage integrator for a 1-bit stream with synchronous clear.
// Latency: acc1/acc2 reflect a sample one cycle after it is accepted (en_i high).
// No backpressure: a sample is accumulated on every clock edge with en_i high.
// Ports: clk, rst_n (sync, active-low); clr_i zeroes both accumulators;
//        en_i/bit_i accumulate one sample; acc1_o/acc2_o are the running sums.
module iadc_sinc2_integrator
  import iadc_pkg::*;
#(
  parameter int ACC1_W = acc1_w(IADC_OSR),
  parameter int ACC2_W = acc2_w(IADC_OSR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [ACC1_W-1:0] acc1_o,
  output logic [ACC2_W-1:0] acc2_o
);

  logic [ACC1_W-1:0] acc1_q, acc1_d;
  logic [ACC2_W-1:0] acc2_q, acc2_d;

  // Second stage adds the already-updated first stage, so after k samples
  // acc2 = sum of acc1 over those k samples (unit weight on the newest one).
  always_comb begin
    acc1_d = acc1_q;
    acc2_d = acc2_q;
    if (clr_i) begin
      acc1_d = '0;
      acc2_d = '0;
    end else if (en_i) begin
      acc1_d = acc1_q + ACC1_W'(bit_i);
      acc2_d = acc2_q + ACC2_W'(acc1_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc1_q <= '0;
      acc2_q <= '0;
    end else begin
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
    end
  end

  assign acc1_o = acc1_q;
  assign acc2_o = acc2_q;

endmodule

// File: rtl/iadc_sinc2_filter.sv
// Incremental sinc2 filter: OSR modulator bits per conversion -> saturated OUT_W-bit code.
// Latency: result strobes OSR+2 cycles after the conversion starts; back-to-back period OSR+2.
// No backpressure: valid is a single-cycle strobe; data_out holds until the next result.
// Ports: clk, rst_n (sync, active-low); io (slave side of iadc_sinc2_filter_if):
//        en, bit_in in; mod_rst, busy, valid, data_out out.
module iadc_sinc2_filter
  import iadc_pkg::*;
#(
  parameter int OSR   = IADC_OSR,
  parameter int SHIFT = IADC_SHIFT,
  parameter int OUT_W = IADC_OUT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  iadc_sinc2_filter_if.slave  io
);

  localparam int CNT_W  = cnt_w(OSR);
  localparam int ACC1_W = acc1_w(OSR);
  localparam int ACC2_W = acc2_w(OSR);
  // Compare width wide enough for both the shifted sum and the code ceiling
  localparam int SAT_W  = (ACC2_W > OUT_W) ? ACC2_W : OUT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [SAT_W-1:0] CODE_MAX = SAT_W'({OUT_W{1'b1}});

  iadc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [ACC1_W-1:0] acc1;
  logic [ACC2_W-1:0] acc2;
  logic [SAT_W-1:0]  acc2_shr;
  logic [OUT_W-1:0]  code_sat;

  // Integrators are cleared in RESET_MOD so every conversion starts from zero,
  // matching the modulator being held in reset at the same time.
  iadc_sinc2_integrator #(
    .ACC1_W (ACC1_W),
    .ACC2_W (ACC2_W)
  ) u_integrator (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == ST_RESET_MOD),
    .en_i   (state_q == ST_INTEGRATE),
    .bit_i  (io.bit_in),
    .acc1_o (acc1),
    .acc2_o (acc2)
  );

  // Scale down and clamp; near full scale acc2 >> SHIFT exceeds the code range.
  always_comb begin
    acc2_shr = SAT_W'(acc2 >> SHIFT);
    code_sat = (acc2_shr > CODE_MAX) ? {OUT_W{1'b1}} : acc2_shr[OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.en) state_d = ST_RESET_MOD;
      end
      ST_RESET_MOD: begin
        cnt_d   = '0;
        state_d = ST_INTEGRATE;
      end
      ST_INTEGRATE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        // acc2 is final here: the last sample landed on the edge entering DUMP
        data_d  = code_sat;
        valid_d = 1'b1;
        state_d = io.en ? ST_RESET_MOD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Modulator only runs while samples are being integrated
  assign io.mod_rst  = (state_q != ST_INTEGRATE);
  assign io.busy     = (state_q != ST_IDLE);
  assign io.valid    = valid_q;
  assign io.data_out = data_q;

endmodule
